// File: rtl/note_bank_synth.sv
// note_bank_synth: polyphonic square-wave note bank.
// Each voice runs a phase counter against its live period and an amplitude
// envelope; all voice samples are summed, clamped and registered into mix_out.
// Optional feature macro: NOTE_BANK_ENVELOPE_EN
//   defined   : attack / sustain / release envelope, paced by a prescaler tick
//   undefined : plain gated square wave at full amplitude
module note_bank_synth #(
   parameter int NUM_VOICES   = 21,
   parameter int PERIOD_W     = 20,
   parameter int AMP_W        = 16,
   parameter int OUT_W        = 32,
   parameter int ENV_DIV      = 50000,
   parameter int ATTACK_STEP  = 64,
   parameter int RELEASE_STEP = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_VOICES-1:0]          play_note,
   input  logic [NUM_VOICES*PERIOD_W-1:0] periods,
   output logic signed [OUT_W-1:0]        mix_out,
   output logic [NUM_VOICES-1:0]          active_mask
);

   // Accumulator is wide enough that the sum of all voices cannot wrap.
   localparam int SUM_W = OUT_W + $clog2(NUM_VOICES) + 1;

   localparam logic [AMP_W-1:0] AMP_MAX = {1'b0, {(AMP_W-1){1'b1}}};

   localparam logic signed [SUM_W-1:0] MIX_MAX =
      {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIX_MIN =
      {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } voice_state_t;

   voice_state_t            state_p0  [NUM_VOICES];
   logic [PERIOD_W-1:0]     cnt_p0    [NUM_VOICES];
   logic [AMP_W-1:0]        level_p0  [NUM_VOICES];

   voice_state_t            state_nxt [NUM_VOICES];
   logic [PERIOD_W-1:0]     cnt_nxt   [NUM_VOICES];
   logic [AMP_W-1:0]        level_nxt [NUM_VOICES];

   logic [PERIOD_W-1:0]     period_v  [NUM_VOICES];
   logic signed [SUM_W-1:0] mix_sum;

   // Next phase value: wraps after period-1, and also recovers at once when a
   // live period change has left the counter at or beyond the new period.
   function automatic logic [PERIOD_W-1:0] phase_advance(
      input logic [PERIOD_W-1:0] cnt,
      input logic [PERIOD_W-1:0] period
   );
      logic [PERIOD_W:0] inc;
      inc = {1'b0, cnt} + (PERIOD_W+1)'(1);
      if (inc >= {1'b0, period})
         return '0;
      return inc[PERIOD_W-1:0];
   endfunction

   // Signed contribution of one voice; periods 0 and 1 cannot form a square
   // wave, so they are silent while the envelope keeps running.
   function automatic logic signed [SUM_W-1:0] voice_sample(
      input voice_state_t        st,
      input logic [PERIOD_W-1:0] cnt,
      input logic [PERIOD_W-1:0] period,
      input logic [AMP_W-1:0]    level
   );
      logic signed [SUM_W-1:0] mag;
      mag = $signed({{(SUM_W-AMP_W){1'b0}}, level});
      if (st == IDLE || period < PERIOD_W'(2))
         return '0;
      if (cnt < (period >> 1))
         return mag;
      return -mag;
   endfunction

   // Clamp the wide sum into the signed OUT_W output range.
   function automatic logic signed [OUT_W-1:0] saturate(
      input logic signed [SUM_W-1:0] x
   );
      if (x > MIX_MAX)
         return MIX_MAX[OUT_W-1:0];
      if (x < MIX_MIN)
         return MIX_MIN[OUT_W-1:0];
      return x[OUT_W-1:0];
   endfunction

`ifdef NOTE_BANK_ENVELOPE_EN
   localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);
   localparam logic [AMP_W:0]   ATK_INC  = (AMP_W+1)'(ATTACK_STEP);
   localparam logic [AMP_W:0]   REL_DEC  = (AMP_W+1)'(RELEASE_STEP);

   logic [DIV_W-1:0] presc_p0;
   logic             env_tick;

   // Attack step, saturating at full scale.
   function automatic logic [AMP_W-1:0] attack_level(input logic [AMP_W-1:0] lvl);
      logic [AMP_W:0] sum;
      sum = {1'b0, lvl} + ATK_INC;
      if (sum >= {1'b0, AMP_MAX})
         return AMP_MAX;
      return sum[AMP_W-1:0];
   endfunction

   // Release step, floored at silence.
   function automatic logic [AMP_W-1:0] release_level(input logic [AMP_W-1:0] lvl);
      if ({1'b0, lvl} <= REL_DEC)
         return '0;
      return lvl - REL_DEC[AMP_W-1:0];
   endfunction

   assign env_tick = (presc_p0 == DIV_LAST);

   // Envelope prescaler: free-running 0..ENV_DIV-1, tick on the last count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         presc_p0 <= '0;
      else if (env_tick)
         presc_p0 <= '0;
      else
         presc_p0 <= presc_p0 + DIV_W'(1);
   end
`endif

   // Slice the packed period bus into one field per voice.
   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_period
      assign period_v[g] = periods[g*PERIOD_W +: PERIOD_W];
   end

   // Per-voice next state: gate changes win over the envelope tick.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         state_nxt[i] = state_p0[i];
         cnt_nxt[i]   = phase_advance(cnt_p0[i], period_v[i]);
         level_nxt[i] = level_p0[i];
         case (state_p0[i])
`ifdef NOTE_BANK_ENVELOPE_EN
            IDLE: begin
               cnt_nxt[i]   = '0;
               level_nxt[i] = '0;
               if (play_note[i])
                  state_nxt[i] = ATTACK;
            end
            ATTACK: begin
               if (!play_note[i]) begin
                  state_nxt[i] = RELEASE;
               end else if (env_tick) begin
                  level_nxt[i] = attack_level(level_p0[i]);
                  if (level_nxt[i] == AMP_MAX)
                     state_nxt[i] = SUSTAIN;
               end
            end
            SUSTAIN: begin
               level_nxt[i] = AMP_MAX;
               if (!play_note[i])
                  state_nxt[i] = RELEASE;
            end
            RELEASE: begin
               // Retrigger resumes from the current level and keeps the phase.
               if (play_note[i]) begin
                  state_nxt[i] = ATTACK;
               end else if (env_tick) begin
                  level_nxt[i] = release_level(level_p0[i]);
                  if (level_nxt[i] == '0) begin
                     state_nxt[i] = IDLE;
                     cnt_nxt[i]   = '0;
                  end
               end
            end
            default: begin
               state_nxt[i] = IDLE;
               cnt_nxt[i]   = '0;
               level_nxt[i] = '0;
            end
`else
            IDLE: begin
               cnt_nxt[i]   = '0;
               level_nxt[i] = '0;
               if (play_note[i]) begin
                  state_nxt[i] = SUSTAIN;
                  level_nxt[i] = AMP_MAX;
               end
            end
            default: begin
               // Only SUSTAIN is reachable here; the gate alone decides.
               if (!play_note[i]) begin
                  state_nxt[i] = IDLE;
                  cnt_nxt[i]   = '0;
                  level_nxt[i] = '0;
               end else begin
                  state_nxt[i] = SUSTAIN;
                  level_nxt[i] = AMP_MAX;
               end
            end
`endif
         endcase
      end
   end

   // ---- stage p0: voice registers ----
   // Voice state, phase and level registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            state_p0[i] <= IDLE;
            cnt_p0[i]   <= '0;
            level_p0[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            state_p0[i] <= state_nxt[i];
            cnt_p0[i]   <= cnt_nxt[i];
            level_p0[i] <= level_nxt[i];
         end
      end
   end

   // Voice activity flags straight from the state registers.
   always_comb begin
      active_mask = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         active_mask[i] = (state_p0[i] != IDLE);
   end

   // Wide sum of all voice samples.
   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         mix_sum = mix_sum + voice_sample(state_p0[i], cnt_p0[i], period_v[i], level_p0[i]);
   end

   // ---- stage p1: registered mix ----
   // Saturated mix register, one clock behind the voice registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         mix_out <= '0;
      else
         mix_out <= saturate(mix_sum);
   end

endmodule

// File: tb/tb_note_bank_synth.sv
// Directed bench for note_bank_synth with 4 voices, 8-bit periods and levels,
// 9-bit mix. Follows NOTE_BANK_ENVELOPE_EN so it matches the RTL build.
module tb_note_bank_synth;
   localparam int NV = 4;
   localparam int PW = 8;
   localparam int AW = 8;
   localparam int OW = 9;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic [NV-1:0]        play_note = '0;
   logic [NV*PW-1:0]     periods = '0;
   logic signed [OW-1:0] mix_out;
   logic [NV-1:0]        active_mask;

   int n_checks = 0;
   int n_pass   = 0;
   int ecount   = 0;

   note_bank_synth #(
      .NUM_VOICES(NV), .PERIOD_W(PW), .AMP_W(AW), .OUT_W(OW),
      .ENV_DIV(4), .ATTACK_STEP(32), .RELEASE_STEP(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .play_note(play_note),
      .periods(periods),
      .mix_out(mix_out),
      .active_mask(active_mask)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Advance to 1ns after rising edge number e (edges counted from reset release).
   task automatic step_to(input int e);
      while (ecount < e) begin
         @(posedge clock);
         #1;
         ecount++;
      end
   endtask

   task automatic set_period(input int v, input int p);
      periods[v*PW +: PW] = PW'(p);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock.
   task automatic async_reset(input logic [NV-1:0] gate_after);
      #2 reset = 1'b1;
      #1;
      chk("rst_mix", mix_out, 0);
      chk("rst_mask", active_mask, 0);
      play_note = gate_after;
      #2 reset = 1'b0;
      ecount = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      #1 reset = 1'b1;
      #2;
      chk("por_mix", mix_out, 0);
      chk("por_mask", active_mask, 0);
      set_period(0, 10);
      play_note = 4'b0001;
      #9 reset = 1'b0;      // t=12, first counted edge at t=15
      ecount = 0;

`ifdef NOTE_BANK_ENVELOPE_EN
      // Attack ramp: ticks land on edges 4,8,12,16; mix lags one edge.
      step_to(1);
      chk("atk_mask", active_mask, 1);
      chk("atk_mix_e1", mix_out, 0);
      step_to(5);  chk("atk_32", mix_out, 32);
      step_to(7);  chk("atk_32_low", mix_out, -32);
      step_to(9);  chk("atk_64", mix_out, -64);
      step_to(13); chk("atk_96", mix_out, 96);
      step_to(17); chk("atk_127", mix_out, -127);
      for (int e = 22; e <= 31; e++) begin
         step_to(e);
         chk($sformatf("sus_e%0d", e), mix_out, (e < 27) ? 127 : -127);
      end

      // Release with level steps on ticks, then retrigger keeping the phase.
      step_to(32); play_note = 4'b0000;
      step_to(33); chk("rel_mask", active_mask, 1);
      step_to(36); chk("rel_hold", mix_out, 127);
      step_to(37); chk("rel_111", mix_out, -111);
      step_to(41); chk("rel_95", mix_out, -95);
      step_to(45); chk("rel_79", mix_out, 79);
      play_note = 4'b0001;
      step_to(47); chk("retrig_79", mix_out, -79);
      step_to(49); chk("retrig_111", mix_out, -111);
      step_to(53); chk("retrig_127", mix_out, 127);

      // Reset mid-note, then the voice stays idle with the gate low.
      async_reset(4'b0000);
      step_to(3);
      chk("post_rst_mask", active_mask, 0);
      chk("post_rst_mix", mix_out, 0);

      // Saturation: four in-phase voices at full level.
      for (int v = 0; v < NV; v++) set_period(v, 20);
      async_reset(4'b1111);
      step_to(17); chk("sat_neg_e17", mix_out, -256);
      chk("sat_mask", active_mask, 15);
      step_to(22); chk("sat_pos", mix_out, 255);
      step_to(32); chk("sat_neg", mix_out, -256);

      // Degenerate period on voice 1.
      set_period(1, 0);
      async_reset(4'b0010);
      step_to(10); chk("deg0_attack_mix", mix_out, 0);
      step_to(20); chk("deg0_mask", active_mask, 2);
      chk("deg0_mix", mix_out, 0);
      set_period(1, 1);
      step_to(25); chk("deg1_mix", mix_out, 0);
      chk("deg1_mask", active_mask, 2);
`else
      // Gated square wave: full amplitude one clock after the gate edge.
      step_to(1);
      chk("gate_mask", active_mask, 1);
      chk("gate_mix_e1", mix_out, 0);
      for (int e = 2; e <= 11; e++) begin
         step_to(e);
         chk($sformatf("gate_e%0d", e), mix_out, (e < 7) ? 127 : -127);
      end
      step_to(12); play_note = 4'b0000;
      step_to(13);
      chk("off_mask", active_mask, 0);
      chk("off_lag", mix_out, 127);
      step_to(14); chk("off_mix", mix_out, 0);

      // Reset mid-note.
      play_note = 4'b0001;
      step_to(16); chk("renote_mix", mix_out, 127);
      for (int v = 0; v < NV; v++) set_period(v, 20);
      async_reset(4'b1111);

      // Saturation: four in-phase voices.
      step_to(2);  chk("sat_pos", mix_out, 255);
      chk("sat_mask", active_mask, 15);
      step_to(12); chk("sat_neg", mix_out, -256);

      // Degenerate period on voice 1.
      set_period(1, 0);
      async_reset(4'b0010);
      step_to(3);
      chk("deg0_mask", active_mask, 2);
      chk("deg0_mix", mix_out, 0);
      set_period(1, 1);
      step_to(6); chk("deg1_mix", mix_out, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/note_bank_synth.md
# note_bank_synth

Parametrised polyphonic square-wave note bank: NUM_VOICES independent tone generators, each with a run-time period and an attack/sustain/release amplitude envelope. All voices are summed into one registered, saturating signed sample. Sits between the key/sequencer gate logic and the audio codec interface, replacing fixed-pitch, fixed-amplitude per-note generators with one configurable block.

## Interface
- NUM_VOICES, 21, number of voices
- PERIOD_W, 20, width of each voice period field (full period in clock cycles)
- AMP_W, 16, envelope level width; AMP_MAX = 2^(AMP_W-1)-1
- OUT_W, 32, mix output width (signed)
- ENV_DIV, 50000, clocks per envelope tick (≥1)
- ATTACK_STEP, 64, level increment per tick in ATTACK
- RELEASE_STEP, 16, level decrement per tick in RELEASE

- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- play_note  in  NUM_VOICES  per-voice gate; bit i high = voice i held
- periods  in  NUM_VOICES*PERIOD_W  voice i period at [i*PERIOD_W +: PERIOD_W]
- mix_out  out  OUT_W  signed saturated sum of voices, registered
- active_mask  out  NUM_VOICES  bit i high when voice i not IDLE

## Operation
- Prescaler counts 0..ENV_DIV-1 and wraps; env_tick is asserted in the cycle it equals ENV_DIV-1.
- Per voice: phase counter cnt (PERIOD_W bits), level (AMP_W bits unsigned), state IDLE/ATTACK/SUSTAIN/RELEASE.
- IDLE: cnt=0, level=0. play_note=1 → ATTACK; cnt cleared.
- ATTACK: on env_tick, level = min(level+ATTACK_STEP, AMP_MAX); reaching AMP_MAX → SUSTAIN in that same edge.
- SUSTAIN: level held at AMP_MAX.
- ATTACK or SUSTAIN with play_note=0 → RELEASE (any cycle, no tick needed).
- RELEASE: on env_tick, level = max(level-RELEASE_STEP, 0); reaching 0 → IDLE. play_note=1 → ATTACK from the current level; cnt not cleared.
- Gate transitions take priority over the tick update in the same cycle: the state changes, and the level updates on the next qualifying tick.
- Phase: in non-IDLE states cnt increments each clock and wraps to 0 after period-1. Voice high while cnt < (period>>1).
- Periods are sampled live. If cnt ≥ period after a period change, cnt wraps to 0 on the next clock.
- Period 0 or 1: voice sample is 0; the envelope still runs.
- Voice sample = high ? +level : -level; IDLE contributes 0.
- Mix: samples summed at width OUT_W+clog2(NUM_VOICES)+1, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then registered into mix_out.

## Timing
- Reset: mix_out=0, active_mask=0, all voices IDLE, cnt=0, level=0, prescaler=0. Asserting reset mid-note silences on the reset edge with no release ramp.
- play_note rising at edge k: active_mask bit set after edge k. The first nonzero level appears after the first env_tick edge that follows.
- mix_out reflects the voice registers from the previous edge: latency of 1 clock.
- Attack time from zero = ceil(AMP_MAX/ATTACK_STEP) ticks. Release time from AMP_MAX = ceil(AMP_MAX/RELEASE_STEP) ticks.

## Configuration
- NOTE_BANK_ENVELOPE_EN defined: full ADSR-less envelope as above.
- NOTE_BANK_ENVELOPE_EN undefined:
  - play_note=1 puts the voice directly in SUSTAIN with level=AMP_MAX and cnt cleared.
  - play_note=0 returns it directly to IDLE with level=0.
  - ATTACK and RELEASE are unreachable, and the prescaler, ATTACK_STEP and RELEASE_STEP are unused.
  - Behaviour is a gated square wave.

## Test plan
Bench params: NUM_VOICES=4, PERIOD_W=8, AMP_W=8 (AMP_MAX=127), OUT_W=9, ENV_DIV=4, ATTACK_STEP=32, RELEASE_STEP=16, macro defined.
- Reset mid-note: assert reset asynchronously while voice 0 is in SUSTAIN → mix_out=0 and active_mask=0 immediately, without waiting for a clock edge; after release, voice 0 is IDLE.
- Attack ramp: voice 0 period=10, play_note=0001 held → level steps 32, 64, 96, 127 on successive ticks, then SUSTAIN. mix_out alternates +127 for 5 clocks and -127 for 5 clocks, 1 clock after the level registers.
- Release and retrigger: drop the gate in SUSTAIN → level 111, 95, 79 on ticks. Raise the gate again → ATTACK resumes from 79 (next tick 111), and the phase is not reset.
- Saturation: all 4 voices at period=20 in SUSTAIN and in phase → raw sum ±508, mix_out clamps to +255 / -256.
- Degenerate period: voice 1 period=0 or 1 with the gate held → active_mask bit 1 = 1 and mix_out=0.
- Macro undefined: play_note=0001 → mix_out=±127 one clock after the gate edge. Gate low → mix_out=0 one clock later.
